fft_iter_core: RTL and testbench
================================

# fft_iter_core

Parametrised, iterative radix-2 DIT FFT/IFFT engine that replaces the fixed 8-point, fully unrolled transform. It accepts one complex sample per cycle through a valid/ready stream and stores it bit-reversed in an internal register file. It then runs log2(NUM_POINT) stages of one butterfly per cycle and streams results out in natural order. The transform direction is selected per frame, and the IFFT's 1/N scaling is distributed as an arithmetic shift of 1 per stage.

## Interface
- NUM_POINT, 8: transform size; power of two, 8..256.
- DATA_W, 16: signed sample width per real/imag component.
- FRAC_W, 12: fraction bits of samples; twiddles are signed, FRAC_W+2 bits wide, with FRAC_W fraction bits.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine accepts a sample this cycle.
- in_real / in_imag  in  DATA_W each  input sample.
- inverse  in  1  0 = FFT, 1 = IFFT; sampled with the first sample of a frame.
- out_valid  out  1  output sample valid.
- out_ready  in  1  consumer accepts the output sample.
- out_real / out_imag  out  DATA_W each  output sample, in natural bin order.
- out_last  out  1  marks bin NUM_POINT-1.
- busy  out  1  high in CALC and UNLOAD.

## Operation
- FSM states:
  - LOAD: in_ready=1. On each in_valid&&in_ready, write mem[bitrev(ld_cnt)] and increment ld_cnt. When ld_cnt==0 at acceptance, latch inverse into mode_r. Accepting sample NUM_POINT-1 moves to CALC.
  - CALC: stage s runs 0..L-1, where L = log2 NUM_POINT. Butterfly counter b runs 0..NUM_POINT/2-1, and half = 2^s.
    - top = (b>>s)*2*half + (b&(half-1)); bot = top+half; twiddle index k = (b&(half-1))*(NUM_POINT/(2*half)).
    - Each cycle, read mem[top] and mem[bot] combinationally and write both results at the clock edge.
    - After the last butterfly of stage L-1, move to UNLOAD.
  - UNLOAD: out_valid=1 and out data = mem[out_cnt]. out_cnt increments on out_valid&&out_ready. Acceptance at out_cnt==NUM_POINT-1 (out_last=1) returns to LOAD, and all counters return to 0.
- Twiddles:
  - W[k] = cos(2πk/N) - j·sin(2πk/N) in FFT mode, with the imaginary part negated in IFFT mode.
  - The table is computed by a constant function at elaboration and rounded to nearest.
  - No twiddle inputs exist.
- Butterfly arithmetic:
  - t = bot·W. Full complex product; each component is arithmetic-shifted right by FRAC_W (truncation).
  - A' = top + t and B' = top - t, formed at DATA_W+2 bits.
  - IFFT: A' and B' are arithmetic-shifted right by 1 before narrowing. FFT: no shift.
  - Narrowing to DATA_W follows Configuration.
- Memory is not reset. Only control state and counters are.
- Reset (any state, including mid-CALC or mid-UNLOAD):
  - state=LOAD, all counters 0, mode_r=0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, busy=0, out_real=out_imag=0.
  - Any partial frame is discarded.
- out_real/out_imag are forced to 0 outside UNLOAD.

## Timing
- Load: NUM_POINT accepted samples, at a minimum of NUM_POINT cycles.
- Compute: exactly (NUM_POINT/2)·L cycles (N=8: 12). No stalls.
- First out_valid appears in the cycle after the final CALC cycle.
- Minimum frame period is 2·NUM_POINT + (NUM_POINT/2)·L cycles (N=8: 28).
- Input and output do not overlap. in_ready=0 throughout CALC and UNLOAD.
- While out_valid&&!out_ready, out data and out_last hold stable.
- in_valid outside LOAD is ignored. inverse is ignored except at the first accepted sample.

## Configuration
- FFT_SAT_EN defined: narrowing to DATA_W saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- FFT_SAT_EN undefined: narrowing keeps the low DATA_W bits (two's-complement wrap).

## Test plan
All scenarios use N=8, DATA_W=16, FRAC_W=12.
- Impulse FFT: x[0]=0x1000, others 0, inverse=0 -> all 8 bins real=0x1000, imag=0x0000.
- DC FFT: all x=0x0100 -> bin0 real=0x0800; bins 1..7 = 0; first out_valid exactly 13 cycles after the 8th accepted sample.
- IFFT: all bins real=0x1000, inverse=1 -> x[0]=0x1000; x[1..7]=0; imag all 0.
- Overflow: all x real=0x7000 FFT -> bin0 real=0x7FFF with FFT_SAT_EN and 0x8000 without; other bins 0.
- Backpressure: deassert out_ready for 5 cycles at out_cnt=3 -> bin 3 held stable, no bin lost or duplicated, out_last only on bin 7.
- Reset mid-CALC: assert reset at stage 1 -> in_ready=1, out_valid=0 immediately; the next full frame (impulse) produces the correct results.

Source files
------------

// File: rtl/fft_iter_core.sv
// Iterative radix-2 DIT FFT/IFFT: bit-reversed load, one butterfly per cycle, natural-order unload.
// Optional macro FFT_SAT_EN: saturate butterfly outputs to DATA_W instead of two's-complement wrap.
module fft_iter_core #(
  parameter int NUM_POINT = 8,
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  input  logic              inverse,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic              out_last,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake rule for both streams: a transfer happens on a rising edge where
  // valid && ready; the producer holds data stable while valid && !ready.

  localparam int LOG2  = $clog2(NUM_POINT);
  localparam int BW    = LOG2 - 1;
  localparam int HALF  = NUM_POINT / 2;
  localparam int TW_W  = FRAC_W + 2;
  localparam int STG_W = $clog2(LOG2 + 1);
  localparam int SW    = DATA_W + 2;
  localparam int PW    = DATA_W + TW_W + 1;

  localparam logic [LOG2-1:0]  LAST_IDX = LOG2'(NUM_POINT - 1);
  localparam logic [BW-1:0]    LAST_BF  = BW'(HALF - 1);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(LOG2 - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_CALC   = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

  // Taylor series keeps the table a pure elaboration-time computation.
  function automatic logic [HALF*TW_W-1:0] make_tab(input bit want_sin);
    logic [HALF*TW_W-1:0] tab;
    real ang, term, acc, scaled;
    int v;
    tab = '0;
    for (int k = 0; k < HALF; k++) begin
      ang  = 2.0 * 3.14159265358979323846 * real'(k) / real'(NUM_POINT);
      term = want_sin ? ang : 1.0;
      acc  = term;
      for (int n = 1; n < 30; n++) begin
        if (want_sin) term = -term * ang * ang / (real'(2 * n) * real'(2 * n + 1));
        else          term = -term * ang * ang / (real'(2 * n - 1) * real'(2 * n));
        acc = acc + term;
      end
      scaled = acc * real'(1 << FRAC_W);
      v = (scaled >= 0.0) ? $rtoi(scaled + 0.5) : -$rtoi(0.5 - scaled);
      tab[k*TW_W +: TW_W] = TW_W'(v);
    end
    return tab;
  endfunction

  localparam logic [HALF*TW_W-1:0] COS_TAB = make_tab(1'b0);
  localparam logic [HALF*TW_W-1:0] SIN_TAB = make_tab(1'b1);

  function automatic logic [LOG2-1:0] bitrev(input logic [LOG2-1:0] a);
    logic [LOG2-1:0] r;
    for (int i = 0; i < LOG2; i++) r[i] = a[LOG2-1-i];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] narrow(input logic signed [SW-1:0] v);
`ifdef FFT_SAT_EN
    if (!v[SW-1] && (v[SW-2:DATA_W-1] != '0))
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (v[SW-1] && !(&v[SW-2:DATA_W-1]))
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return v[DATA_W-1:0];
`else
    return DATA_W'(v);
`endif
  endfunction

  state_t             state;
  logic [LOG2-1:0]    ld_cnt;
  logic [LOG2-1:0]    out_cnt;
  logic [BW-1:0]      bfly;
  logic [STG_W-1:0]   stage;
  logic               mode_r;

  logic signed [DATA_W-1:0] mem_re [NUM_POINT];
  logic signed [DATA_W-1:0] mem_im [NUM_POINT];

  logic [LOG2-1:0]          ld_addr, top_a, bot_a;
  logic [BW-1:0]            half_mask, low_b, tw_k;
  logic signed [TW_W-1:0]   w_re, w_im, sin_k;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [PW-1:0]     p_re, p_im;
  logic signed [SW-1:0]     t_re, t_im, s_re, s_im, d_re, d_im;
  logic [DATA_W-1:0]        n_s_re, n_s_im, n_d_re, n_d_im;

  assign ld_addr = bitrev(ld_cnt);

  // Butterfly addressing: top = (b>>s)*2*half + (b mod half), bot = top + half.
  always_comb begin
    half_mask = (BW'(1) << stage) - BW'(1);
    low_b     = bfly & half_mask;
    tw_k      = low_b << (STG_W'(BW) - stage);
    top_a     = ((LOG2'(bfly) >> stage) << (stage + 1'b1)) | LOG2'(low_b);
    bot_a     = top_a | (LOG2'(1) << stage);
  end

  always_comb begin
    w_re  = $signed(COS_TAB[tw_k*TW_W +: TW_W]);
    sin_k = $signed(SIN_TAB[tw_k*TW_W +: TW_W]);
    w_im  = mode_r ? sin_k : -sin_k;
    a_re  = mem_re[top_a];
    a_im  = mem_im[top_a];
    b_re  = mem_re[bot_a];
    b_im  = mem_im[bot_a];
    p_re  = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
    p_im  = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
    t_re  = SW'(p_re >>> FRAC_W);
    t_im  = SW'(p_im >>> FRAC_W);
    s_re  = SW'(a_re) + t_re;
    s_im  = SW'(a_im) + t_im;
    d_re  = SW'(a_re) - t_re;
    d_im  = SW'(a_im) - t_im;
    // IFFT 1/N scaling spread as one halving per stage.
    if (mode_r) begin
      s_re = s_re >>> 1;
      s_im = s_im >>> 1;
      d_re = d_re >>> 1;
      d_im = d_im >>> 1;
    end
    n_s_re = narrow(s_re);
    n_s_im = narrow(s_im);
    n_d_re = narrow(d_re);
    n_d_im = narrow(d_im);
  end

  // Sample storage carries no reset; only control is reset.
  always_ff @(posedge clock) begin
    if (state == ST_LOAD && in_valid) begin
      mem_re[ld_addr] <= in_real;
      mem_im[ld_addr] <= in_imag;
    end else if (state == ST_CALC) begin
      mem_re[top_a] <= n_s_re;
      mem_im[top_a] <= n_s_im;
      mem_re[bot_a] <= n_d_re;
      mem_im[bot_a] <= n_d_im;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_LOAD;
      ld_cnt    <= '0;
      out_cnt   <= '0;
      bfly      <= '0;
      stage     <= '0;
      mode_r    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            if (ld_cnt == '0) mode_r <= inverse;
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == LAST_IDX) begin
              state    <= ST_CALC;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          bfly <= bfly + 1'b1;
          if (bfly == LAST_BF) begin
            bfly <= '0;
            if (stage == LAST_STG) begin
              stage     <= '0;
              state     <= ST_UNLOAD;
              out_valid <= 1'b1;
            end else begin
              stage <= stage + 1'b1;
            end
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_cnt == LAST_IDX) begin
              out_cnt   <= '0;
              state     <= ST_LOAD;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_LOAD;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_last  = out_valid && (out_cnt == LAST_IDX);
  assign out_real  = out_valid ? mem_re[out_cnt] : '0;
  assign out_imag  = out_valid ? mem_im[out_cnt] : '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_fft_iter_core.sv
// Directed bench for fft_iter_core (N=8): scoreboard queue filled by the stimulus, drained by a monitor.
module tb_fft_iter_core;

  localparam int N  = 8;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_real = '0;
  logic [DW-1:0] in_imag = '0;
  logic          inverse = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_real;
  logic [DW-1:0] out_imag;
  logic          out_last;
  logic          busy;
  logic [1:0]    dbg_state;

  fft_iter_core #(.NUM_POINT(N), .DATA_W(DW), .FRAC_W(12)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .inverse(inverse),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_last(out_last), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int popped = 0;
  int acc_cyc = 0;

  logic [DW-1:0] fr_re [N];
  logic [DW-1:0] fr_im [N];
  logic [DW-1:0] ex_re [N];
  logic [DW-1:0] ex_im [N];

  // Scoreboard entries are {out_last, out_real, out_imag}
  logic [2*DW:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push_expected();
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), ex_re[i], ex_im[i]});
  endtask

  task automatic set_frame(input logic [DW-1:0] re_all);
    for (int i = 0; i < N; i++) begin
      fr_re[i] = re_all;
      fr_im[i] = '0;
      ex_re[i] = '0;
      ex_im[i] = '0;
    end
  endtask

  // Driver: inverse is flipped after the first sample to show it is only sampled there.
  task automatic send_frame(input logic inv, input bit gaps);
    int g;
    int guard;
    for (int i = 0; i < N; i++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      in_valid = 1'b0;
      repeat (g) begin @(posedge clock); #1; end
      guard = 0;
      while (!in_ready && guard < 200) begin @(posedge clock); #1; guard++; end
      if (!in_ready) begin
        total++; bad++;
        $display("FAIL in_ready_wait got=0 want=1");
        in_valid = 1'b0;
        return;
      end
      in_valid = 1'b1;
      in_real  = fr_re[i];
      in_imag  = fr_im[i];
      inverse  = (i == 0) ? inv : ~inv;
      acc_cyc  = cyc;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge clock); #1; n++; end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: pops on each accepted output; checks hold stability while stalled.
  logic [2*DW:0] got_v, exp_v, held;
  bit held_v = 1'b0;
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      got_v = {out_last, out_real, out_imag};
      if (held_v) begin
        total++;
        if (got_v !== held) begin
          bad++;
          $display("FAIL hold_stable got=%h want=%h", got_v, held);
        end
      end
      if (out_ready) begin
        held_v = 1'b0;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output got=%h want=none", got_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (got_v !== exp_v) begin
            bad++;
            $display("FAIL bin%0d got=%h want=%h", popped % N, got_v, exp_v);
          end
          popped++;
        end
      end else begin
        held   = got_v;
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    int w;
    int base;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_data",  {out_real, out_imag}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Impulse FFT: flat spectrum.
    set_frame('0);
    fr_re[0] = 16'h1000;
    for (int i = 0; i < N; i++) ex_re[i] = 16'h1000;
    push_expected();
    send_frame(1'b0, 1'b1);
    wait_drain();

    // DC FFT plus latency; stray in_valid during CALC must be ignored.
    set_frame(16'h0100);
    ex_re[0] = 16'h0800;
    push_expected();
    send_frame(1'b0, 1'b0);
    in_valid = 1'b1;
    in_real  = 16'h7777;
    w = 0;
    while (!out_valid && w < 100) begin @(negedge clock); w++; end
    in_valid = 1'b0;
    check("dc_latency", 32'(cyc - acc_cyc), 32'd13);
    check("dc_busy_unload", 32'(busy), 32'd1);
    check("dc_in_ready_unload", 32'(in_ready), 32'd0);
    wait_drain();

    // IFFT of flat spectrum is an impulse.
    set_frame(16'h1000);
    ex_re[0] = 16'h1000;
    push_expected();
    send_frame(1'b1, 1'b1);
    wait_drain();

    // Overflow growth through all stages.
    set_frame(16'h7000);
`ifdef FFT_SAT_EN
    ex_re[0] = 16'h7FFF;
`else
    ex_re[0] = 16'h8000;
`endif
    push_expected();
    send_frame(1'b0, 1'b0);
    wait_drain();

    // Shifted impulse x[1]: X[k] = 0x1000*W^k, stalled at bin 3.
    set_frame('0);
    fr_re[1] = 16'h1000;
    ex_re[0] = 16'h1000; ex_im[0] = 16'h0000;
    ex_re[1] = 16'h0B50; ex_im[1] = 16'hF4B0;
    ex_re[2] = 16'h0000; ex_im[2] = 16'hF000;
    ex_re[3] = 16'hF4B0; ex_im[3] = 16'hF4B0;
    ex_re[4] = 16'hF000; ex_im[4] = 16'h0000;
    ex_re[5] = 16'hF4B0; ex_im[5] = 16'h0B50;
    ex_re[6] = 16'h0000; ex_im[6] = 16'h1000;
    ex_re[7] = 16'h0B50; ex_im[7] = 16'h0B50;
    push_expected();
    base = popped;
    send_frame(1'b0, 1'b1);
    w = 0;
    while (popped != base + 3 && w < 200) begin @(posedge clock); #1; w++; end
    check("bp_reach_bin3", 32'(popped - base), 32'd3);
    out_ready = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    check("bp_stalled_bin3_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_drain();
    check("bp_pop_count", 32'(popped - base), 32'd8);

    // Reset during stage 1 of CALC.
    set_frame(16'h0123);
    send_frame(1'b0, 1'b0);
    repeat (5) begin @(posedge clock); #1; end
    check("mid_calc_state", 32'(dbg_state), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_state",     32'(dbg_state), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    set_frame('0);
    fr_re[0] = 16'h1000;
    for (int i = 0; i < N; i++) ex_re[i] = 16'h1000;
    push_expected();
    send_frame(1'b0, 1'b1);
    wait_drain();
    repeat (2) @(posedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
